// File: rtl/up_counter_4bit.sv
// ---------------------------------------------------------------------------
// up_counter_4bit
//   Parameterised synchronous binary up-counter with enable, synchronous
//   clear, parallel load (clamped to the terminal value) and a programmable
//   terminal value. It is used as a general event/cycle counter. The tc and
//   wrap flags feed downstream timing logic.
//
// Parameters
//   WIDTH    counter width in bits (1..32)
//   MAX_VAL  terminal value, 1..2**WIDTH-1; the count wraps to 0 after it
//
// Ports
//   clk   in   1      rising-edge clock
//   rst   in   1      synchronous reset, active low (overrides everything)
//   en    in   1      count enable
//   clr   in   1      synchronous clear, active high (highest priority)
//   load  in   1      synchronous parallel load, active high
//   d     in   WIDTH  load value (values above MAX_VAL saturate to MAX_VAL)
//   q     out  WIDTH  registered count
//   tc    out  1      combinational, high while q == MAX_VAL
//   wrap  out  1      registered one-cycle pulse after a counting MAX_VAL->0
// ---------------------------------------------------------------------------
module up_counter_4bit #(
    parameter int unsigned      WIDTH   = 4,
    parameter longint unsigned  MAX_VAL = (64'd1 << WIDTH) - 64'd1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

    // Terminal value at the counter's own width.
    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_VAL);

    // Catch illegal configurations at elaboration time.
    generate
        if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
            $error("up_counter_4bit: WIDTH must be 1..32");
        end
        if (MAX_VAL < 1 || MAX_VAL > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_max
            $error("up_counter_4bit: MAX_VAL must be 1..2**WIDTH-1");
        end
    endgenerate

    logic [WIDTH-1:0] q_nxt;
    logic             wrap_nxt;

    // Next-state selection, priority clr > load > en > hold. Every branch
    // keeps q_nxt within 0..MAX_VAL, so the increment can never overflow.
    always_comb begin
        q_nxt    = q;
        wrap_nxt = 1'b0;
        if (clr) begin
            q_nxt = '0;
        end else if (load) begin
            q_nxt = (d > MAX_Q) ? MAX_Q : d;
        end else if (en) begin
            if (q == MAX_Q) begin
                q_nxt    = '0;
                wrap_nxt = 1'b1;   // only a counting rollover flags wrap
            end else begin
                q_nxt = q + WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            q    <= '0;
            wrap <= 1'b0;
        end else begin
            q    <= q_nxt;
            wrap <= wrap_nxt;
        end
    end

    assign tc = (q == MAX_Q);

endmodule

// File: tb/tb_up_counter_4bit.sv
module tb_up_counter_4bit;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       clr = 1'b0;
    logic       load = 1'b0;
    logic [3:0] d = 4'd0;

    logic [3:0] q15, q11;
    logic       tc15, tc11, wrap15, wrap11;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Default configuration: 0..15.
    up_counter_4bit dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load), .d(d),
        .q(q15), .tc(tc15), .wrap(wrap15)
    );

    // Programmable terminal value: 0..11.
    up_counter_4bit #(.WIDTH(4), .MAX_VAL(11)) dut11 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load), .d(d),
        .q(q11), .tc(tc11), .wrap(wrap11)
    );

    typedef struct {
        logic       rst, en, clr, load;
        logic [3:0] d;
        int         q;
        logic       tc, wrap;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, e, c, l, input int dv,
                                input int eq, input logic et, ew);
        vec_t v;
        v.rst = r; v.en = e; v.clr = c; v.load = l; v.d = 4'(dv);
        v.q = eq; v.tc = et; v.wrap = ew;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one set of inputs across a rising edge, then settle before sampling.
    task automatic step(input logic r, e, c, l, input logic [3:0] dv);
        rst = r; en = e; clr = c; load = l; d = dv;
        @(posedge clk);
        #1;
    endtask

    // Reference behaviour from the rules: modulo (mx+1) counting with clamp.
    task automatic model(input int mx, input logic r, e, c, l, input int dv,
                         inout int mq, inout int mw);
        if (!r)      begin mq = 0; mw = 0; end
        else if (c)  begin mq = 0; mw = 0; end
        else if (l)  begin mq = (dv > mx) ? mx : dv; mw = 0; end
        else if (e)  begin mw = (mq == mx) ? 1 : 0; mq = (mq + 1) % (mx + 1); end
        else         mw = 0;
    endtask

    initial begin
        // ---- table for the default 0..15 counter ----
        tbl.push_back(mk(0,0,0,0,0, 0,0,0));                   // reset
        for (int i = 1; i <= 14; i++) tbl.push_back(mk(1,1,0,0,0, i,0,0));
        tbl.push_back(mk(1,1,0,0,0, 15,1,0));                  // terminal
        tbl.push_back(mk(1,1,0,0,0, 0,0,1));                   // wrap pulse
        tbl.push_back(mk(1,1,0,0,0, 1,0,0));                   // pulse gone
        // enable / hold
        tbl.push_back(mk(1,0,0,1,5, 5,0,0));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(1,0,0,0,0, 5,0,0));
        tbl.push_back(mk(1,1,0,0,0, 6,0,0));
        // load and priority
        tbl.push_back(mk(1,0,0,1,9, 9,0,0));
        tbl.push_back(mk(1,0,0,1,7, 7,0,0));
        tbl.push_back(mk(1,1,1,1,3, 0,0,0));                   // clr wins
        tbl.push_back(mk(1,1,0,1,3, 3,0,0));                   // load, no inc
        // reset mid-count
        tbl.push_back(mk(1,0,0,1,12, 12,0,0));
        tbl.push_back(mk(0,1,0,0,0, 0,0,0));
        tbl.push_back(mk(1,1,0,0,0, 1,0,0));
        // reset and clr both kill a pending wrap
        tbl.push_back(mk(1,0,0,1,15, 15,1,0));
        tbl.push_back(mk(1,1,0,0,0, 0,0,1));
        tbl.push_back(mk(0,1,0,0,0, 0,0,0));
        tbl.push_back(mk(1,0,0,1,15, 15,1,0));
        tbl.push_back(mk(1,1,1,0,0, 0,0,0));
        tbl.push_back(mk(1,0,0,0,0, 0,0,0));                   // hold keeps wrap low

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].en, tbl[i].clr, tbl[i].load, tbl[i].d);
            chk($sformatf("tbl[%0d].q", i),    int'(q15),    tbl[i].q);
            chk($sformatf("tbl[%0d].tc", i),   int'(tc15),   int'(tbl[i].tc));
            chk($sformatf("tbl[%0d].wrap", i), int'(wrap15), int'(tbl[i].wrap));
        end

        // ---- MAX_VAL=11: clamp, terminal, wrap ----
        step(0,0,0,0,0);
        chk("m11.reset.q", int'(q11), 0);
        chk("m11.reset.tc", int'(tc11), 0);
        step(1,0,0,1,14);
        chk("m11.clamp.q", int'(q11), 11);
        chk("m11.clamp.tc", int'(tc11), 1);
        chk("m15.noclamp.q", int'(q15), 14);
        step(1,1,0,0,0);
        chk("m11.wrap.q", int'(q11), 0);
        chk("m11.wrap.wrap", int'(wrap11), 1);
        chk("m11.wrap.tc", int'(tc11), 0);
        step(1,1,0,0,0);
        chk("m11.after.q", int'(q11), 1);
        chk("m11.after.wrap", int'(wrap11), 0);
        step(1,0,0,1,11);
        chk("m11.load_max.q", int'(q11), 11);
        step(1,1,0,0,0);
        chk("m11.load_max_wrap", int'(wrap11), 1);

        // ---- randomized run against the reference model ----
        begin
            int mq15 = 0, mw15 = 0, mq11 = 0, mw11 = 0;
            step(0,0,0,0,0);
            chk("rnd.reset15", int'(q15), 0);
            chk("rnd.reset11", int'(q11), 0);
            for (int i = 0; i < 600; i++) begin
                logic r, e, c, l;
                logic [3:0] dv;
                r  = ($urandom_range(0, 39) != 0);
                e  = ($urandom_range(0, 9) < 8);
                c  = ($urandom_range(0, 24) == 0);
                l  = ($urandom_range(0, 14) == 0);
                dv = 4'($urandom_range(0, 15));
                model(15, r, e, c, l, int'(dv), mq15, mw15);
                model(11, r, e, c, l, int'(dv), mq11, mw11);
                step(r, e, c, l, dv);
                chk($sformatf("rnd[%0d].q15", i),    int'(q15),    mq15);
                chk($sformatf("rnd[%0d].tc15", i),   int'(tc15),   (mq15 == 15) ? 1 : 0);
                chk($sformatf("rnd[%0d].wrap15", i), int'(wrap15), mw15);
                chk($sformatf("rnd[%0d].q11", i),    int'(q11),    mq11);
                chk($sformatf("rnd[%0d].tc11", i),   int'(tc11),   (mq11 == 11) ? 1 : 0);
                chk($sformatf("rnd[%0d].wrap11", i), int'(wrap11), mw11);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/up_counter_4bit.md
Name: up_counter_4bit

Overview:
- Synchronous, parameterised binary up-counter with enable, synchronous clear, parallel load and a programmable terminal value.
- Default configuration is a free-running 4-bit counter, 0..15, wrapping to 0.
- Used as a general-purpose event and cycle counter. It also drives downstream timing logic through its terminal-count and wrap flags.

Parameters:
- WIDTH, 4, counter width in bits (legal 1..32).
- MAX_VAL, 2**WIDTH-1, terminal value. The counter wraps to 0 after reaching it. Legal range 1..2**WIDTH-1.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  synchronous, active-low reset; sampled on the rising clk edge.
- en  input  1  count enable. Tie to 1 for free-running operation.
- clr  input  1  synchronous clear to 0, active-high.
- load  input  1  synchronous parallel load, active-high.
- d  input  WIDTH  load value.
- q  output  WIDTH  current count, registered.
- tc  output  1  combinational terminal-count flag: 1 when q == MAX_VAL.
- wrap  output  1  registered one-cycle pulse: 1 in the cycle after q advanced from MAX_VAL to 0 via counting.

Behaviour:
- Reset:
  - At a rising edge with rst==0: q <= 0 and wrap <= 0.
  - tc is therefore 0 after reset (MAX_VAL >= 1).
  - Reset overrides all other inputs.
  - Before the first reset edge, outputs are undefined (X in simulation).
- Priority at each rising edge with rst==1: clr > load > en > hold.
  - clr==1: q <= 0; wrap <= 0.
  - else load==1: if d > MAX_VAL then q <= MAX_VAL (saturating clamp), otherwise q <= d; wrap <= 0.
  - else en==1:
    - if q == MAX_VAL: q <= 0 and wrap <= 1.
    - otherwise: q <= q + 1 and wrap <= 0.
  - else: q holds; wrap <= 0.
- Latency: one cycle from a sampled input to the q update. tc follows q combinationally, with no extra delay.
- Arithmetic: unsigned modulo (MAX_VAL+1). The next-state value never exceeds MAX_VAL and never overflows WIDTH bits.
- wrap is never asserted for two consecutive cycles unless MAX_VAL==0 (illegal, excluded).
  - With MAX_VAL==1 and en held high, wrap alternates.
- Simultaneous events:
  - clr together with load: clear wins.
  - load together with en: the load value is taken; no increment in that cycle.
- Reset mid-count: q returns to 0 on the reset edge regardless of en/load/clr. Counting resumes on the first rising edge with rst==1 and en==1, which yields q=1.
- Inputs are assumed synchronous to clk; no internal synchronisers.

Test Plan:
- Basic count: rst=0 for 1 edge, then rst=1, en=1, clr=0, load=0 for 10 edges -> q sequence 1,2,...,10; tc=0; wrap=0 throughout.
- Wrap (default params): free-run 17 edges from reset -> q reaches 15 with tc=1, then q=0 with wrap=1 for exactly one cycle, then q=1.
- Enable/hold: count to 5, drop en for 3 edges -> q stays 5. Raise en -> next edge q=6.
- Load and clamp:
  - load=1, d=9 -> q=9 next edge.
  - With MAX_VAL=11, load d=14 -> q=11 and tc=1.
  - Next en edge -> q=0, wrap=1.
- Priority: at q=7 assert clr=1, load=1, d=3, en=1 together -> q=0. Then load=1, en=1, d=3 -> q=3 (no increment).
- Reset mid-operation: at q=12 with en=1, drive rst=0 for one edge -> q=0 and wrap=0. Release -> q=1 on the following edge.
